// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit and the data memory.
// The unit is the master; memory answers with ack and read data.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte-lane steering, alignment checks and a
// single-outstanding memory request with an ack timeout.
module load_store_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_access,
  output logic        err_timeout,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        ld_q;
  logic        done_q;
  logic        eacc_q;
  logic        eto_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        illegal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  assign accept = (state_q == IDLE) && start
                && (is_load ^ is_store);

  always_comb begin
    illegal = 1'b0;
    if (funct3 inside {3'b011, 3'b110, 3'b111})
      illegal = 1'b1;
    if (is_store && funct3[2])
      illegal = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0])
      illegal = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
      illegal = 1'b1;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      (funct3[1:0] == 2'b01): begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
    if (!is_store)
      wdata_d = '0;
  end

  // Lane select uses the byte offset captured at acceptance.
  always_comb begin
    byte_v = mem.mem_rdata[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? mem.mem_rdata[31:16]
                       : mem.mem_rdata[15:0];
    ext_v  = mem.mem_rdata;
    unique case (1'b1)
      (f3_q == 3'b000): ext_v = {{24{byte_v[7]}}, byte_v};
      (f3_q == 3'b100): ext_v = {24'b0, byte_v};
      (f3_q == 3'b001): ext_v = {{16{half_v[15]}}, half_v};
      (f3_q == 3'b101): ext_v = {16'b0, half_v};
      default:          ext_v = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      eacc_q  <= 1'b0;
      eto_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      eacc_q  <= 1'b0;
      eto_q   <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            f3_q   <= funct3;
            lane_q <= addr[1:0];
            ld_q   <= is_load;
            if (illegal) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              eacc_q  <= 1'b1;
            end else begin
              state_q <= REQ;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= is_store;
              addr_q  <= {addr[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= ld_q ? ext_v : '0;
          end else if (cnt_q == LAST) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            eto_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err_access    = eacc_q;
  assign err_timeout   = eto_q;
  assign load_data     = rdata_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the max cycles mem_req is held without mem_ack before abort (legal 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  execute stage presents a memory op this cycle.
REQ-005 is_load  input  1  op is a load.
REQ-006 is_store  input  1  op is a store.
REQ-007 funct3  input  3  width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  effective address (ALU result).
REQ-009 store_data  input  32  rs2 value.
REQ-010 busy  output  1  unit occupied; upstream stalls.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 load_data  output  32  extended load result, valid while done=1.
REQ-013 err_access  output  1  misaligned/illegal-width flag, valid with done.
REQ-014 err_timeout  output  1  ack timeout flag, valid with done.
REQ-015 mem_req, mem_we  output  1 each  bus request; write strobe.
REQ-016 mem_addr, mem_wdata  output  32 each  word-aligned address; lane-replicated write data.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_ack  input  1  bus acceptance/completion; mem_rdata  input  32  read word, valid with mem_ack.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DONE; busy = (state != IDLE).
REQ-020 In IDLE, start=1 with exactly one of is_load/is_store SHALL be accepted; start with both or neither set SHALL be ignored (no state change, no done).
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 Access illegal when: funct3 in {011,110,111}; store with funct3 in {100,101}; H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-023 Illegal accepted op SHALL go IDLE->DONE, never assert mem_req, and assert done=1, err_access=1, load_data=0 in the DONE cycle.
REQ-024 Legal accepted op SHALL go IDLE->REQ; mem_addr={addr[31:2],2'b00}, mem_we, mem_be, mem_wdata registered at acceptance and held constant throughout REQ.
REQ-025 Store lanes: B be=0001<<addr[1:0], wdata={4{d[7:0]}}; H be=0011 (addr[1]=0) or 1100, wdata={2{d[15:0]}}; W be=1111, wdata=d. Loads: mem_be per same rule, mem_wdata=0.
REQ-026 mem_req SHALL be 1 exactly in REQ; mem_ack outside REQ SHALL be ignored.
REQ-027 mem_ack=1 sampled in REQ SHALL move to DONE; for loads load_data SHALL register the lane at addr[1:0] (B/BU byte, H/HU halfword at addr[1]*16), sign-extended for B/H, zero-extended for BU/HU, full word for W.
REQ-028 Store completion SHALL give load_data=0.
REQ-029 Latency: start accepted at edge N, mem_req=1 in cycle N+1; ack at edge N+1 gives done in cycle N+2 (minimum 2-cycle op).
REQ-030 A cycle counter SHALL clear on REQ entry and increment each REQ cycle without ack; after ACK_TIMEOUT REQ cycles without ack, SHALL go to DONE with err_timeout=1, load_data=0, mem_req deasserting.
REQ-031 Ack in the final permitted cycle SHALL count as success (no timeout).
REQ-032 DONE SHALL last exactly one cycle then return to IDLE; done, err_access, err_timeout SHALL be 0 outside DONE.
REQ-033 Next start SHALL be acceptable in the cycle after DONE.

Reset
REQ-034 rst=1 at an edge SHALL force IDLE and clear counter; outputs then: busy=0, done=0, err_access=0, err_timeout=0, load_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
REQ-035 rst during REQ or DONE SHALL abort without done pulse; rst has priority over start and mem_ack in the same cycle.

Verification
REQ-036 SB addr=0x1003, store_data=0xAABBCCDD, ack immediate -> mem_addr=0x1000, be=1000, wdata=0xDDDDDDDD, mem_we=1, done cycle N+2.
REQ-037 LB addr=0x2001, mem_rdata=0x1234F678 -> load_data=0xFFFFFFF6; LHU addr=0x2002 same data -> 0x00001234.
REQ-038 LW addr=0x3002 -> no mem_req, done=1 with err_access=1 at N+1, load_data=0; funct3=011 likewise.
REQ-039 LW, ACK_TIMEOUT=16, ack withheld -> mem_req high exactly 16 cycles, then done+err_timeout; ack on 16th cycle -> normal done.
REQ-040 start with is_load=is_store=1 and start while busy -> ignored; back-to-back ops accepted in cycle after done.
REQ-041 rst asserted during 3rd REQ cycle -> next cycle mem_req=0, busy=0, no done pulse.
